// File: rtl/mesh_link_fifo_if.sv
// Handshake bundle for mesh_link_fifo.
// The slave modport is the link stage's own view: it takes the upstream
// word stream (In_Req/In_Data) and the downstream acknowledge (Out_Ack),
// and drives In_Ack, the downstream word stream and the status outputs.
// The master modport is the surrounding tiles' view (directions mirrored).
//   In_Req/In_Data/In_Ack          upstream 4-phase word stream
//   Out_Req/Out_Data/Out_Ack       downstream 4-phase word stream
//   Out_Last                       Out_Data closes its packet
//   Fill                           FIFO occupancy
//   Pkt_Count                      packets delivered, wraps
interface mesh_link_fifo_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic              In_Req;
    logic [31:0]       In_Data;
    logic              In_Ack;
    logic              Out_Req;
    logic [31:0]       Out_Data;
    logic              Out_Ack;
    logic              Out_Last;
    logic [FILL_W-1:0] Fill;
    logic [CNT_W-1:0]  Pkt_Count;

    modport slave (
        input  In_Req, In_Data, Out_Ack,
        output In_Ack, Out_Req, Out_Data, Out_Last, Fill, Pkt_Count
    );

    modport master (
        output In_Req, In_Data, Out_Ack,
        input  In_Ack, Out_Req, Out_Data, Out_Last, Fill, Pkt_Count
    );
endinterface

// File: rtl/mesh_link_fifo.sv
// Mesh link stage between two tiles. Accepts 4-phase words from the sending
// tile, buffers them in a DEPTH-entry FIFO tagged with a packet-last flag
// derived from header framing, and replays them as 4-phase words to the
// receiving tile, counting completed packets.
// Ports:
//   HCLK    clock, rising edge
//   HRESET  synchronous reset, active-high
//   lnk     mesh_link_fifo_if.slave (In_*, Out_*, Fill, Pkt_Count)
// All outputs are registered, so there is no combinational path between
// the upstream and downstream sides.
module mesh_link_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic           HCLK,
    input  logic           HRESET,
    mesh_link_fifo_if.slave lnk
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    typedef enum logic       {IN_IDLE, IN_ACK} in_st_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_REL} out_st_t;

    in_st_t           in_st;
    out_st_t          out_st;
    logic [32:0]      mem [DEPTH];     // {last, word}
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [FW-1:0]    fill;
    logic             expect_hdr;
    logic [8:0]       words_left;
    logic             in_ack, out_req, out_last;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] pkt_count;

    logic       full, push, pop, push_last;
    logic [8:0] hdr_words;

    // Full is judged on the registered occupancy: a pop in the same cycle
    // does not open a slot until the next cycle.
    assign full      = (fill == FW'(DEPTH));
    assign push      = (in_st == IN_IDLE) && lnk.In_Req && !full;
    assign pop       = (out_st == OUT_REQ) && lnk.Out_Ack;
    assign hdr_words = ({1'b0, lnk.In_Data[15:8]} + 9'd3) >> 2;
    assign push_last = expect_hdr ? (hdr_words == 9'd0) : (words_left == 9'd1);

    // Storage carries no reset; entries are only read when counted in fill.
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= {push_last, lnk.In_Data};
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            in_st      <= IN_IDLE;
            in_ack     <= 1'b0;
            wr_ptr     <= '0;
            expect_hdr <= 1'b1;
            words_left <= '0;
        end else begin
            case (in_st)
                IN_IDLE: if (push) begin
                    in_ack <= 1'b1;
                    in_st  <= IN_ACK;
                    wr_ptr <= wr_ptr + 1'b1;
                    words_left <= expect_hdr ? hdr_words : words_left - 9'd1;
                    expect_hdr <= push_last;
                end
                IN_ACK: if (!lnk.In_Req) begin
                    in_ack <= 1'b0;
                    in_st  <= IN_IDLE;
                end
                default: in_st <= IN_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            out_st    <= OUT_IDLE;
            out_req   <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            rd_ptr    <= '0;
            pkt_count <= '0;
        end else begin
            case (out_st)
                OUT_IDLE: if (fill != '0 && !lnk.Out_Ack) begin
                    out_data <= mem[rd_ptr][31:0];
                    out_last <= mem[rd_ptr][32];
                    out_req  <= 1'b1;
                    out_st   <= OUT_REQ;
                end
                OUT_REQ: if (lnk.Out_Ack) begin
                    out_req   <= 1'b0;
                    rd_ptr    <= rd_ptr + 1'b1;
                    pkt_count <= pkt_count + CNT_W'(out_last);
                    out_st    <= OUT_REL;
                end
                OUT_REL: if (!lnk.Out_Ack) out_st <= OUT_IDLE;
                default: out_st <= OUT_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) fill <= '0;
        else if (push && !pop) fill <= fill + 1'b1;
        else if (pop && !push) fill <= fill - 1'b1;
    end

    assign lnk.In_Ack    = in_ack;
    assign lnk.Out_Req   = out_req;
    assign lnk.Out_Data  = out_data;
    assign lnk.Out_Last  = out_last;
    assign lnk.Fill      = fill;
    assign lnk.Pkt_Count = pkt_count;
endmodule

// File: tb/tb_mesh_link_fifo.sv
// Self-checking bench for mesh_link_fifo: directed framing, back-pressure
// and reset scenarios plus a randomized packet stream scored against a
// packet-level reference queue.
module tb_mesh_link_fifo;
    localparam int TMO = 3000;

    logic clk, rst;
    int   n_chk, n_pass;
    bit   tmo_hit;

    mesh_link_fifo_if #(.DEPTH(4), .CNT_W(8)) lnk ();
    mesh_link_fifo #(.DEPTH(4), .CNT_W(8)) dut (.HCLK(clk), .HRESET(rst), .lnk(lnk));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ack_lvl);
        rst = 1'b1;
        lnk.In_Req = 1'b0;
        lnk.In_Data = '0;
        lnk.Out_Ack = ack_lvl;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic start_req(input logic [31:0] w, input int dly);
        repeat (dly) tick();
        lnk.In_Data = w;
        lnk.In_Req = 1'b1;
    endtask

    task automatic finish_req();
        int t;
        t = 0;
        while (!lnk.In_Ack && t < TMO) begin tick(); t++; end
        if (!lnk.In_Ack) begin
            n_chk++; tmo_hit = 1'b1;
            $display("FAIL in_ack_rise timeout: In_Ack=%b required 1", lnk.In_Ack);
        end
        lnk.In_Req = 1'b0;
        t = 0;
        while (lnk.In_Ack && t < TMO) begin tick(); t++; end
        if (lnk.In_Ack) begin
            n_chk++; tmo_hit = 1'b1;
            $display("FAIL in_ack_fall timeout: In_Ack=%b required 0", lnk.In_Ack);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int dly);
        start_req(w, dly);
        finish_req();
    endtask

    task automatic recv_word(output logic [31:0] d, output logic l, input int dly);
        int t;
        t = 0;
        d = 'x; l = 1'bx;
        while (!lnk.Out_Req && t < TMO) begin tick(); t++; end
        if (!lnk.Out_Req) begin
            n_chk++; tmo_hit = 1'b1;
            $display("FAIL out_req_rise timeout: Out_Req=%b required 1", lnk.Out_Req);
            return;
        end
        d = lnk.Out_Data;
        l = lnk.Out_Last;
        repeat (dly) tick();
        lnk.Out_Ack = 1'b1;
        t = 0;
        do begin tick(); t++; end while (lnk.Out_Req && t < TMO);
        if (lnk.Out_Req) begin
            n_chk++; tmo_hit = 1'b1;
            $display("FAIL out_req_fall timeout: Out_Req=%b required 0", lnk.Out_Req);
        end
        lnk.Out_Ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_chk++;
        if ({lnk.In_Ack, lnk.Out_Req, lnk.Out_Data, lnk.Out_Last, lnk.Fill, lnk.Pkt_Count} !== '0)
            $display("FAIL reset_state: got ack=%b req=%b data=%h last=%b fill=%0d cnt=%0d required all 0",
                     lnk.In_Ack, lnk.Out_Req, lnk.Out_Data, lnk.Out_Last, lnk.Fill, lnk.Pkt_Count);
        else n_pass++;
    endtask

    task automatic test_hdr_only();
        logic [31:0] d; logic l;
        send_word(32'h0123_0010, 0);
        recv_word(d, l, 0);
        n_chk++;
        if ({l, d} !== {1'b1, 32'h0123_0010})
            $display("FAIL hdr_only_word: got last=%b data=%h required last=1 data=01230010", l, d);
        else n_pass++;
        n_chk++;
        if (lnk.Pkt_Count !== 8'd1)
            $display("FAIL hdr_only_count: got %0d required 1", lnk.Pkt_Count);
        else n_pass++;
    endtask

    task automatic test_short_pkt();
        logic [31:0] w [3];
        logic [31:0] d; logic l;
        logic [7:0] base;
        w[0] = 32'h02_11_05_22; w[1] = 32'hA; w[2] = 32'hB;
        base = lnk.Pkt_Count;
        for (int i = 0; i < 3; i++) send_word(w[i], 0);
        for (int i = 0; i < 3; i++) begin
            recv_word(d, l, i);
            n_chk++;
            if ({l, d} !== {(i == 2), w[i]})
                $display("FAIL short_pkt_word%0d: got last=%b data=%h required last=%b data=%h",
                         i, l, d, (i == 2), w[i]);
            else n_pass++;
        end
        n_chk++;
        if (lnk.Pkt_Count !== base + 8'd1)
            $display("FAIL short_pkt_count: got %0d required %0d", lnk.Pkt_Count, base + 8'd1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] w [6];
        logic [31:0] d [6];
        logic        l [6];
        bit          early_ack;
        do_reset(1'b0);
        // header L=20 -> 5 payload words, so all 6 words form one packet
        w[0] = 32'h03_44_14_55;
        for (int i = 1; i < 6; i++) w[i] = 32'hC0DE_0000 + 32'(i);
        for (int i = 0; i < 4; i++) send_word(w[i], 0);
        n_chk++;
        if (lnk.Fill !== 3'd4) $display("FAIL bp_fill: got %0d required 4", lnk.Fill);
        else n_pass++;
        start_req(w[4], 0);
        early_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (lnk.In_Ack) early_ack = 1'b1;
        end
        n_chk++;
        if (early_ack) $display("FAIL bp_stall: In_Ack rose while full, required 0");
        else n_pass++;
        n_chk++;
        if ({lnk.Out_Req, lnk.Out_Data} !== {1'b1, w[0]})
            $display("FAIL bp_head: got req=%b data=%h required req=1 data=%h",
                     lnk.Out_Req, lnk.Out_Data, w[0]);
        else n_pass++;
        fork
            begin
                finish_req();
                send_word(w[5], 0);
            end
            begin
                for (int i = 0; i < 6; i++) recv_word(d[i], l[i], 0);
            end
        join
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if ({l[i], d[i]} !== {(i == 5), w[i]})
                $display("FAIL bp_word%0d: got last=%b data=%h required last=%b data=%h",
                         i, l[i], d[i], (i == 5), w[i]);
            else n_pass++;
        end
        n_chk++;
        if ({lnk.Fill, lnk.Pkt_Count} !== {3'd0, 8'd1})
            $display("FAIL bp_final: got fill=%0d cnt=%0d required fill=0 cnt=1", lnk.Fill, lnk.Pkt_Count);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] send_q [$];
        logic [32:0] exp_q [$];
        int lasts, n_words, bad;
        do_reset(1'b0);
        tmo_hit = 1'b0;
        // Reference: packet = header + ceil(L/4) payload words, last on the final one.
        for (int p = 0; p < 1000; p++) begin
            int len, pw;
            logic [31:0] hdr;
            len = $urandom_range(0, 64);
            pw  = (len + 3) / 4;
            hdr = {8'($urandom), 8'($urandom), 8'(len), 8'($urandom)};
            send_q.push_back(hdr);
            exp_q.push_back({(pw == 0), hdr});
            for (int k = 1; k <= pw; k++) begin
                logic [31:0] pl;
                pl = $urandom;
                send_q.push_back(pl);
                exp_q.push_back({(k == pw), pl});
            end
        end
        n_words = send_q.size();
        lasts = 0;
        bad = 0;
        fork
            begin
                for (int i = 0; i < n_words; i++) begin
                    if (tmo_hit) break;
                    send_word(send_q[i], $urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < n_words; i++) begin
                    logic [31:0] d; logic l; logic [32:0] e;
                    if (tmo_hit) break;
                    recv_word(d, l, $urandom_range(0, 1));
                    e = exp_q.pop_front();
                    n_chk++;
                    if ({l, d} !== e)
                        $display("FAIL rand_word%0d: got last=%b data=%h required last=%b data=%h",
                                 i, l, d, e[32], e[31:0]);
                    else n_pass++;
                    if (l === 1'b1) lasts++;
                end
            end
        join
        n_chk++;
        if (lnk.Pkt_Count !== 8'd232) $display("FAIL rand_pkt_count: got %0d required 232", lnk.Pkt_Count);
        else n_pass++;
        n_chk++;
        if (lasts != 1000) $display("FAIL rand_last_count: got %0d required 1000", lasts);
        else n_pass++;
        n_chk++;
        if (lnk.Fill !== 3'd0 || exp_q.size() != 0)
            $display("FAIL rand_drain: got fill=%0d pending=%0d required 0/0", lnk.Fill, exp_q.size());
        else n_pass++;
        if (bad != 0) n_chk++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic l;
        lnk.Out_Ack = 1'b0;
        // header L=64 leaves the framer mid-packet after three words
        send_word(32'h04_00_40_01, 0);
        send_word(32'h1111_1111, 0);
        send_word(32'h2222_2222, 0);
        n_chk++;
        if ({lnk.Out_Req, lnk.Fill} !== {1'b1, 3'd3})
            $display("FAIL rmid_pre: got req=%b fill=%0d required req=1 fill=3", lnk.Out_Req, lnk.Fill);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({lnk.Out_Req, lnk.Fill, lnk.Pkt_Count, lnk.In_Ack} !== '0)
            $display("FAIL rmid_post: got req=%b fill=%0d cnt=%0d ack=%b required all 0",
                     lnk.Out_Req, lnk.Fill, lnk.Pkt_Count, lnk.In_Ack);
        else n_pass++;
        send_word(32'h05_66_00_77, 0);
        recv_word(d, l, 0);
        n_chk++;
        if ({l, d} !== {1'b1, 32'h05_66_00_77})
            $display("FAIL rmid_hdr: got last=%b data=%h required last=1 data=05660077", l, d);
        else n_pass++;
        n_chk++;
        if (lnk.Pkt_Count !== 8'd1) $display("FAIL rmid_count: got %0d required 1", lnk.Pkt_Count);
        else n_pass++;
    endtask

    task automatic test_ack_high();
        logic [31:0] d; logic l;
        bit req_seen;
        do_reset(1'b1);
        send_word(32'h06_00_00_99, 0);
        req_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (lnk.Out_Req) req_seen = 1'b1;
        end
        n_chk++;
        if (req_seen) $display("FAIL ack_high_noreq: Out_Req rose while Out_Ack=1, required 0");
        else n_pass++;
        lnk.Out_Ack = 1'b0;
        recv_word(d, l, 0);
        n_chk++;
        if ({l, d} !== {1'b1, 32'h06_00_00_99})
            $display("FAIL ack_high_word: got last=%b data=%h required last=1 data=06000099", l, d);
        else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; tmo_hit = 1'b0;
        rst = 1'b1;
        lnk.In_Req = 1'b0; lnk.In_Data = '0; lnk.Out_Ack = 1'b0;
        test_reset();
        test_hdr_only();
        test_short_pkt();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_ack_high();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
